// File: rtl/imem_pkg.sv
// Shared constants for the fetch-stage instruction store: instruction width,
// NOP encoding and the default program image.
package imem_pkg;

  localparam int unsigned INSTR_W    = 16;
  localparam int unsigned IMEM_WORDS = 64;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  // Words 0..41 hold the datapath test program; the remainder are NOPs.
  localparam logic [INSTR_W-1:0] DEFAULT_PROGRAM [IMEM_WORDS] = '{
     0: 16'h1234,  1: 16'h2345,  2: 16'h3456,  3: 16'h4567,
     4: 16'h5678,  5: 16'h6789,  6: 16'h789A,  7: 16'h89AB,
     8: 16'h9ABC,  9: 16'hABCD, 10: 16'hBCDE, 11: 16'hCDEF,
    12: 16'h1111, 13: 16'h2222, 14: 16'h3333, 15: 16'h4444,
    16: 16'h5555, 17: 16'h6666, 18: 16'h7777, 19: 16'h8888,
    20: 16'h9999, 21: 16'hAAAA, 22: 16'hBBBB, 23: 16'hCCCC,
    24: 16'hDDDD, 25: 16'hEEEE, 26: 16'h0F0F, 27: 16'hF0F0,
    28: 16'h1357, 29: 16'h2468, 30: 16'h369C, 31: 16'h48D0,
    32: 16'h5A5A, 33: 16'hA5A5, 34: 16'h0102, 35: 16'h0304,
    36: 16'h0506, 37: 16'h0708, 38: 16'h090A, 39: 16'h0B0C,
    40: 16'h0D0E, 41: 16'hF00D,
    default: NOP_INSTR
  };

endpackage

// File: rtl/instruction_memory.sv
// Word-organised instruction store: combinational read by byte address,
// clocked single-word load port, synchronous reset to the default image.
module instruction_memory
  import imem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] instruction,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  function automatic logic [DATA_W-1:0] default_word(input int unsigned i);
    if (i < IMEM_WORDS)
      return DATA_W'(DEFAULT_PROGRAM[i[5:0]]);
    else
      return DATA_W'(NOP_INSTR);
  endfunction

  function automatic logic [DEPTH-1:0][DATA_W-1:0] default_image();
    logic [DEPTH-1:0][DATA_W-1:0] img;
    for (int unsigned i = 0; i < DEPTH; i++)
      img[i] = default_word(i);
    return img;
  endfunction

  // Declaration initialiser gives the default image at power-up as well.
  logic [DEPTH-1:0][DATA_W-1:0] mem = default_image();

  logic [ADDR_W-1:0] rd_word;
  logic [ADDR_W-1:0] wr_word;

  assign rd_word = address >> 1;
  assign wr_word = load_addr >> 1;

  always_ff @(posedge clk) begin
    if (rst)
      mem <= default_image();
    else if (load_en && (wr_word < DEPTH_A))
      mem[wr_word[IDX_W-1:0]] <= load_data;
  end

  always_comb begin
    instruction = '0;
    if (rd_word < DEPTH_A)
      instruction = mem[rd_word[IDX_W-1:0]];
  end

endmodule

// File: tb/tb_instruction_memory.sv
// Directed bench for instruction_memory with a reference image model and an
// expected-value queue feeding immediate assertions.
module tb_instruction_memory;
  import imem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] address;
  logic [15:0] instruction;
  logic        load_en;
  logic [15:0] load_addr;
  logic [15:0] load_data;

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [15:0] model [64];
  logic [15:0] sb [$];

  instruction_memory #(.ADDR_W(16), .DATA_W(16), .DEPTH(64)) dut (
    .clk(clk),
    .rst(rst),
    .address(address),
    .instruction(instruction),
    .load_en(load_en),
    .load_addr(load_addr),
    .load_data(load_data)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model_read(input logic [15:0] a);
    logic [15:0] w;
    w = a >> 1;
    if (w < 16'd64) return model[w[5:0]];
    return 16'h0000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) model[i] = DEFAULT_PROGRAM[i];
  endtask

  task automatic compare(input string tag);
    logic [15:0] exp;
    exp = sb.pop_front();
    tests++;
    assert (instruction === exp)
    else begin
      fails++;
      $error("FAIL %s addr=%h observed=%h expected=%h", tag, address, instruction, exp);
    end
  endtask

  // Expected value is queued as the address is driven, popped after settle.
  task automatic check_model(input string tag, input logic [15:0] a);
    sb.push_back(model_read(a));
    address = a;
    #1;
    compare(tag);
  endtask

  task automatic check_const(input string tag, input logic [15:0] a, input logic [15:0] exp);
    sb.push_back(exp);
    address = a;
    #1;
    compare(tag);
  endtask

  task automatic sweep(input string tag);
    for (int a = 0; a < 128; a += 2) check_model(tag, 16'(a));
  endtask

  task automatic load_word(input logic [15:0] la, input logic [15:0] ld);
    @(negedge clk);
    load_en = 1'b1; load_addr = la; load_data = ld;
    @(posedge clk);
    #1;
    load_en = 1'b0;
    if ((la >> 1) < 16'd64) model[la[6:1]] = ld;
  endtask

  initial begin
    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0; address = '0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Default image, including the NOP tail
    sweep("reset_sweep");
    check_const("word0", 16'h0000, 16'h1234);
    check_const("word1", 16'h0002, 16'h2345);
    check_const("word2", 16'h0004, 16'h3456);
    check_const("odd_addr", 16'h0003, 16'h2345);
    check_const("oor_0080", 16'h0080, 16'h0000);
    check_const("oor_fffe", 16'hFFFE, 16'h0000);
    check_const("oor_ffff", 16'hFFFF, 16'h0000);

    // Load with same-cycle read: old value before the edge, new after
    @(negedge clk);
    address = 16'h0004;
    load_en = 1'b1; load_addr = 16'h0004; load_data = 16'hABCD;
    #1;
    check_const("pre_edge", 16'h0004, 16'h3456);
    @(posedge clk);
    #1;
    load_en = 1'b0;
    model[2] = 16'hABCD;
    check_const("post_edge", 16'h0004, 16'hABCD);
    sweep("after_load");

    // Odd load address and last word
    load_word(16'h0007, 16'h7777);
    load_word(16'h007F, 16'h1111);
    check_const("odd_load", 16'h0006, 16'h7777);
    check_const("last_word", 16'h007E, 16'h1111);

    // Reset beats load; reads show pre-edge contents while rst is high
    @(negedge clk);
    rst = 1'b1; load_en = 1'b1; load_addr = 16'h0002; load_data = 16'hBEEF;
    check_const("during_rst", 16'h0004, 16'hABCD);
    @(posedge clk);
    #1;
    rst = 1'b0; load_en = 1'b0;
    model_reset();
    check_const("rst_w1", 16'h0002, 16'h2345);
    check_const("rst_w2", 16'h0004, 16'h3456);
    check_const("rst_w3", 16'h0006, 16'h4567);
    check_const("rst_w63", 16'h007E, 16'h0000);

    // Out-of-range loads are dropped
    load_word(16'h0100, 16'h5555);
    load_word(16'h0080, 16'h6666);
    check_const("oor_load", 16'h0080, 16'h0000);
    sweep("oor_load_sweep");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instruction_memory.md
Name: instruction_memory

Overview:
Word-organised instruction store for the pipelined datapath's fetch stage. It takes a 16-bit byte address from the PC and returns the 16-bit instruction combinationally, in the same cycle. The array is preloaded with a default program image. A clocked load port allows the image to be rewritten, and a synchronous reset restores the default image.

Parameters:
ADDR_W, 16, byte-address width of the address and load_addr ports.
DATA_W, 16, instruction width.
DEPTH, 64, number of instruction words stored; must be ≤ 2^(ADDR_W-1).

Ports:
clk  input  1  system clock; all state changes occur on the rising edge.
rst  input  1  synchronous, active-high reset.
address  input  ADDR_W  byte address from the PC; word index = address[ADDR_W-1:1].
instruction  output  DATA_W  instruction word at address; combinational.
load_en  input  1  when high, the word at load_addr is written on the clock edge.
load_addr  input  ADDR_W  byte address for the load; bit 0 ignored.
load_data  input  DATA_W  word to write.

Behaviour:
- Storage: DEPTH words of DATA_W bits, held in flip-flops.
- Power-up and reset: at power-up (simulation initial) and on every clock edge with rst=1, word i takes DEFAULT_PROGRAM[i] for all i. Reset has priority over load_en in the same cycle. Reset mid-program discards all loaded words.
- Read path:
  - instruction = mem[address>>1] with zero cycle latency.
  - instruction is purely combinational on address and current contents, and changes in the same delta as address.
  - Not gated by rst; during reset assertion it shows the pre-edge contents.
- Addressing:
  - Addresses are byte addresses; consecutive instructions are at +2.
  - Bit 0 is ignored, so odd address A reads the same word as A-1.
- Out of range: if (address>>1) ≥ DEPTH, instruction = 0 (NOP encoding). The address never wraps or aliases.
- Load path:
  - Write occurs on the rising edge when rst=0 and load_en=1.
  - The target is (load_addr>>1); a write with an out-of-range target is silently dropped.
- Same-cycle read and write: a read of the word being written returns the old value until the edge, and the new value immediately after. There is no bypass.
- X-safety: if address contains X/Z bits, instruction may be X; no other requirement applies.
- No other outputs, no handshake, no stall.

Decomposition:
- Shared package imem_pkg holds:
  - INSTR_W = 16.
  - NOP_INSTR = 16'h0000.
  - DEFAULT_PROGRAM: array of DEPTH words. The first 42 words are the datapath test program; the remaining words are NOP_INSTR. Sample values are DEFAULT_PROGRAM[0]=16'h1234, [1]=16'h2345, [2]=16'h3456.
- No sub-module is needed; the block is a single module containing the register array, the load/reset write logic and the read mux.

Test Plan:
1. Reset, then sweep address = 0,2,4,…,0x52 with 5 ns steps → instruction equals DEFAULT_PROGRAM[address>>1] at every step: 16'h1234 at 0x0000, 16'h2345 at 0x0002, 16'h3456 at 0x0004.
2. Apply address = 0x0003 → instruction = 16'h2345, identical to 0x0002.
3. Apply address = 0x0080 (word 64 ≥ DEPTH) → instruction = 16'h0000. Then apply 0xFFFE → instruction = 16'h0000.
4. Pulse load_en=1, load_addr=0x0004, load_data=16'hABCD for one edge with address=0x0004:
   - before the edge, instruction = 16'h3456;
   - after the edge, instruction = 16'hABCD;
   - other words are unchanged.
5. In the same cycle, rst=1 and load_en=1 with load_addr=0x0002, load_data=16'hBEEF → after the edge, address 0x0002 reads 16'h2345 and address 0x0004 reads 16'h3456 (default image restored).
6. Load to load_addr=0x0100 with data 16'h5555 → no word changes; a full sweep still matches the current image.
